// File: rtl/if_id_hazard_ctrl.sv
// IF/ID front-end sequencer: load-use stalls, redirect squashes, HALT freeze and stall counter.
// Optional debug single-step support is compiled in when IF_ID_DEBUG_STEP_EN is defined.
module if_id_hazard_ctrl #(
    parameter int NBITS = 32,
    parameter int NREG  = 5
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_ID_EX_MemRead,
    input  logic [NREG-1:0]  i_ID_EX_Rt,
    input  logic [NREG-1:0]  i_IF_ID_Rs,
    input  logic [NREG-1:0]  i_IF_ID_Rt,
    input  logic             i_Branch_Taken,
    input  logic             i_Jump,
    input  logic             i_Halt,
    input  logic             i_Dbg_Step,
    input  logic             i_Dbg_Resume,
    output logic             o_PC_Write,
    output logic             o_IF_ID_Write,
    output logic             o_IF_ID_Flush,
    output logic             o_ID_EX_Bubble,
    output logic             o_Halted,
    output logic [NBITS-1:0] o_stall_count
);

`ifdef IF_ID_DEBUG_STEP_EN
    typedef enum logic [1:0] {RUN = 2'd0, HALT = 2'd1, STEP = 2'd2} state_t;
`else
    typedef enum logic [1:0] {RUN = 2'd0, HALT = 2'd1} state_t;

    logic unused_dbg;
    assign unused_dbg = i_Dbg_Step ^ i_Dbg_Resume;
`endif

    state_t           state_q;
    state_t           state_d;
    logic             lu;
    logic             rd;
    logic             count_en;
    logic [NBITS-1:0] stall_count_q;

    function automatic logic [NBITS-1:0] sat_inc(input logic [NBITS-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign lu = i_ID_EX_MemRead && (i_ID_EX_Rt != '0) &&
                ((i_ID_EX_Rt == i_IF_ID_Rs) || (i_ID_EX_Rt == i_IF_ID_Rt));
    assign rd = i_Branch_Taken || i_Jump;

    // Only live pipeline cycles (RUN or the single STEP cycle) can stall.
    assign count_en = (state_q != HALT) && lu && !rd;

    always_comb begin
        state_d        = state_q;
        o_PC_Write     = 1'b1;
        o_IF_ID_Write  = 1'b1;
        o_IF_ID_Flush  = 1'b0;
        o_ID_EX_Bubble = 1'b0;
        o_Halted       = 1'b0;

        if (state_q == HALT) begin
            o_PC_Write     = 1'b0;
            o_IF_ID_Write  = 1'b0;
            o_ID_EX_Bubble = 1'b1;
            o_Halted       = 1'b1;
        end else if (rd) begin
            o_IF_ID_Flush  = 1'b1;
        end else if (lu) begin
            o_PC_Write     = 1'b0;
            o_IF_ID_Write  = 1'b0;
            o_ID_EX_Bubble = 1'b1;
        end

        case (state_q)
            RUN: begin
                // A redirect squashes the HALT sitting in IF/ID.
                if (i_Halt && !rd) state_d = HALT;
            end
            HALT: begin
`ifdef IF_ID_DEBUG_STEP_EN
                if (i_Dbg_Resume)    state_d = RUN;
                else if (i_Dbg_Step) state_d = STEP;
`endif
            end
`ifdef IF_ID_DEBUG_STEP_EN
            STEP:    state_d = HALT;
`endif
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q       <= RUN;
            stall_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (count_en) stall_count_q <= sat_inc(stall_count_q);
        end
    end

    assign o_stall_count = stall_count_q;

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// Self-checking bench for if_id_hazard_ctrl: directed steps plus randomized traffic
// against a flag-based reference model; a second NBITS=4 instance covers saturation.
module tb_if_id_hazard_ctrl;

    logic        i_clk;
    logic        i_reset_n;
    logic        i_ID_EX_MemRead;
    logic [4:0]  i_ID_EX_Rt;
    logic [4:0]  i_IF_ID_Rs;
    logic [4:0]  i_IF_ID_Rt;
    logic        i_Branch_Taken;
    logic        i_Jump;
    logic        i_Halt;
    logic        i_Dbg_Step;
    logic        i_Dbg_Resume;
    logic        o_PC_Write, o_IF_ID_Write, o_IF_ID_Flush, o_ID_EX_Bubble, o_Halted;
    logic [31:0] o_stall_count;
    logic        s_PC_Write, s_IF_ID_Write, s_IF_ID_Flush, s_ID_EX_Bubble, s_Halted;
    logic [3:0]  s_stall_count;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: frozen flag, pending single-step flag, ideal counters.
    bit          m_halted;
    bit          m_stepping;
    longint      m_cnt;
    int          m_cnt4;

    if_id_hazard_ctrl #(.NBITS(32), .NREG(5)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_ID_EX_MemRead(i_ID_EX_MemRead), .i_ID_EX_Rt(i_ID_EX_Rt),
        .i_IF_ID_Rs(i_IF_ID_Rs), .i_IF_ID_Rt(i_IF_ID_Rt),
        .i_Branch_Taken(i_Branch_Taken), .i_Jump(i_Jump), .i_Halt(i_Halt),
        .i_Dbg_Step(i_Dbg_Step), .i_Dbg_Resume(i_Dbg_Resume),
        .o_PC_Write(o_PC_Write), .o_IF_ID_Write(o_IF_ID_Write),
        .o_IF_ID_Flush(o_IF_ID_Flush), .o_ID_EX_Bubble(o_ID_EX_Bubble),
        .o_Halted(o_Halted), .o_stall_count(o_stall_count)
    );

    if_id_hazard_ctrl #(.NBITS(4), .NREG(5)) dut_sat (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_ID_EX_MemRead(i_ID_EX_MemRead), .i_ID_EX_Rt(i_ID_EX_Rt),
        .i_IF_ID_Rs(i_IF_ID_Rs), .i_IF_ID_Rt(i_IF_ID_Rt),
        .i_Branch_Taken(i_Branch_Taken), .i_Jump(i_Jump), .i_Halt(i_Halt),
        .i_Dbg_Step(i_Dbg_Step), .i_Dbg_Resume(i_Dbg_Resume),
        .o_PC_Write(s_PC_Write), .o_IF_ID_Write(s_IF_ID_Write),
        .o_IF_ID_Flush(s_IF_ID_Flush), .o_ID_EX_Bubble(s_ID_EX_Bubble),
        .o_Halted(s_Halted), .o_stall_count(s_stall_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_halted   = 1'b0;
        m_stepping = 1'b0;
        m_cnt      = 0;
        m_cnt4     = 0;
    endtask

    task automatic drive(input logic mr, input logic [4:0] exrt, input logic [4:0] rs,
                         input logic [4:0] rt, input logic br, input logic jp,
                         input logic hl, input logic st, input logic rs_m);
        i_ID_EX_MemRead = mr;
        i_ID_EX_Rt      = exrt;
        i_IF_ID_Rs      = rs;
        i_IF_ID_Rt      = rt;
        i_Branch_Taken  = br;
        i_Jump          = jp;
        i_Halt          = hl;
        i_Dbg_Step      = st;
        i_Dbg_Resume    = rs_m;
    endtask

    // One clock: drive after the falling edge, check combinational outputs
    // mid-low-phase, then advance the model at the rising edge.
    task automatic do_cycle(input logic mr, input logic [4:0] exrt, input logic [4:0] rs,
                            input logic [4:0] rt, input logic br, input logic jp,
                            input logic hl, input logic st, input logic rs_m);
        bit lu, rd, frozen;
        bit e_pc, e_ifw, e_fl, e_bub, e_hlt;
        @(negedge i_clk);
        drive(mr, exrt, rs, rt, br, jp, hl, st, rs_m);
        #1;
        lu = mr && (exrt != 0) && ((exrt == rs) || (exrt == rt));
        rd = br || jp;
        frozen = m_halted && !m_stepping;
        if (frozen)   {e_pc, e_ifw, e_fl, e_bub, e_hlt} = 5'b00011;
        else if (rd)  {e_pc, e_ifw, e_fl, e_bub, e_hlt} = 5'b11100;
        else if (lu)  {e_pc, e_ifw, e_fl, e_bub, e_hlt} = 5'b00010;
        else          {e_pc, e_ifw, e_fl, e_bub, e_hlt} = 5'b11000;
        chk("pc_write",   {63'd0, o_PC_Write},     {63'd0, e_pc});
        chk("ifid_write", {63'd0, o_IF_ID_Write},  {63'd0, e_ifw});
        chk("ifid_flush", {63'd0, o_IF_ID_Flush},  {63'd0, e_fl});
        chk("idex_bub",   {63'd0, o_ID_EX_Bubble}, {63'd0, e_bub});
        chk("halted",     {63'd0, o_Halted},       {63'd0, e_hlt});
        chk("stall_cnt",  {32'd0, o_stall_count},  m_cnt);
        chk("stall_cnt4", {60'd0, s_stall_count},  m_cnt4);
        @(posedge i_clk);
        if (!frozen) begin
            if (lu && !rd) begin
                if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            if (m_stepping) m_stepping = 1'b0;
            else if (hl && !rd) m_halted = 1'b1;
        end else begin
`ifdef IF_ID_DEBUG_STEP_EN
            if (rs_m)    m_halted = 1'b0;
            else if (st) m_stepping = 1'b1;
`endif
        end
    endtask

    // Asynchronous reset asserted in the high phase, checked before the next edge.
    task automatic do_reset();
        #2;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        i_reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst_pc_write", {63'd0, o_PC_Write},    64'd1);
        chk("rst_halted",   {63'd0, o_Halted},      64'd0);
        chk("rst_cnt",      {32'd0, o_stall_count}, 64'd0);
        chk("rst_cnt4",     {60'd0, s_stall_count}, 64'd0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
    endtask

    initial begin
        i_reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #2;
        chk("init_pc_write",   {63'd0, o_PC_Write},     64'd1);
        chk("init_ifid_write", {63'd0, o_IF_ID_Write},  64'd1);
        chk("init_flush",      {63'd0, o_IF_ID_Flush},  64'd0);
        chk("init_bubble",     {63'd0, o_ID_EX_Bubble}, 64'd0);
        chk("init_halted",     {63'd0, o_Halted},       64'd0);
        chk("init_cnt",        {32'd0, o_stall_count},  64'd0);
        @(negedge i_clk);
        i_reset_n = 1'b1;

        // Load-use stall, then the same pattern against r0.
        do_cycle(1, 5, 5, 0, 0, 0, 0, 0, 0);
        #1 chk("lu_cnt_after", {32'd0, o_stall_count}, 64'd1);
        do_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("r0_cnt_after", {32'd0, o_stall_count}, 64'd1);
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Load-use with a taken branch: flush wins, counter holds.
        do_cycle(1, 5, 0, 5, 1, 0, 0, 0, 0);
        #1 chk("br_lu_cnt", {32'd0, o_stall_count}, 64'd1);
        do_cycle(1, 7, 7, 0, 0, 1, 1, 0, 0);
        #1 chk("jump_squash_halt", {63'd0, o_Halted}, 64'd0);

        // Halt, then single-step.
        do_cycle(0, 0, 0, 0, 0, 0, 1, 0, 0);
        #1 chk("halt_next", {63'd0, o_Halted}, 64'd1);
        do_cycle(1, 3, 3, 0, 0, 0, 0, 0, 0);
        do_cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
`ifdef IF_ID_DEBUG_STEP_EN
        #1 chk("step_halted", {63'd0, o_Halted}, 64'd0);
        chk("step_pc_write", {63'd0, o_PC_Write}, 64'd1);
`else
        #1 chk("step_ignored", {63'd0, o_Halted}, 64'd1);
`endif
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("step_rehalt", {63'd0, o_Halted}, 64'd1);

        // Resume beats a simultaneous step.
        do_cycle(0, 0, 0, 0, 0, 0, 0, 1, 1);
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef IF_ID_DEBUG_STEP_EN
        #1 chk("resume_persist", {63'd0, o_Halted}, 64'd0);
`else
        #1 chk("halt_terminal", {63'd0, o_Halted}, 64'd1);
`endif

        // Asynchronous reset while halted.
        do_cycle(0, 0, 0, 0, 0, 0, 1, 0, 0);
        do_reset();

        // Saturation of the 4-bit instance.
        for (int i = 0; i < 20; i++) do_cycle(1, 9, 9, 9, 0, 0, 0, 0, 0);
        #1 chk("sat_cnt4", {60'd0, s_stall_count}, 64'd15);
        chk("sat_cnt32", {32'd0, o_stall_count}, 64'd20);

        // Randomized traffic with periodic resets.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 49) do_reset();
            else do_cycle($urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 1,
                          $urandom_range(0, 9) < 1, $urandom_range(0, 9) < 2,
                          $urandom_range(0, 9) < 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
